// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg
// Shared definitions for the exception-check handshake (Data/Data_valid/Exc/ACK).
// Imported by both the requester (exc_check_requester) and the checker.
//   exc_code_e     : 3-bit exception codes carried on Exc
//   req_state_e    : requester FSM states
//   QNAN_CANON     : canonical quiet NaN used as special result
//   exc_normalize  : folds unknown codes onto NaN
//   exc_combine    : NaN over inf over normal
// ---------------------------------------------------------------------------
package exc_pkg;

  typedef enum logic [2:0] {
    EXC_NORMAL = 3'b000,
    EXC_INF    = 3'b011,
    EXC_NAN    = 3'b100
  } exc_code_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_A  = 3'd1,
    ST_WAIT_A = 3'd2,
    ST_REQ_B  = 3'd3,
    ST_WAIT_B = 3'd4,
    ST_DONE   = 3'd5
  } req_state_e;

  localparam logic [31:0] QNAN_CANON = 32'h7FC0_0000;

  // Any code the checker is not supposed to produce is treated as NaN so that
  // a misbehaving checker can never make a bad operand look clean.
  function automatic logic [2:0] exc_normalize(input logic [2:0] code);
    case (code)
      EXC_NORMAL: return EXC_NORMAL;
      EXC_INF:    return EXC_INF;
      default:    return EXC_NAN;
    endcase
  endfunction

  function automatic logic [2:0] exc_combine(input logic [2:0] code_a,
                                             input logic [2:0] code_b);
    if (code_a == EXC_NAN || code_b == EXC_NAN) return EXC_NAN;
    if (code_a == EXC_INF || code_b == EXC_INF) return EXC_INF;
    return EXC_NORMAL;
  endfunction

endpackage

// File: rtl/exc_check_requester.sv
// ---------------------------------------------------------------------------
// exc_check_requester
// Initiator side of the exception-check handshake. Latches an operand pair on
// start, presents A then B to the checker, captures each Exc code on ACK and
// reports per-operand and combined codes with a one-cycle done pulse.
//
// Parameters:
//   ACK_TIMEOUT : cycles allowed in a WAIT state without ACK (min 2)
//   TMO_W       : timeout counter width, 2**TMO_W > ACK_TIMEOUT
//
// Ports:
//   CLK, RSTN        clock (rising edge), synchronous active-low reset
//   start            request pulse, op_a/op_b sampled when idle
//   op_a, op_b       IEEE-754 single operands
//   busy             high in every state except idle
//   done             one-cycle pulse, results valid and held until next start
//   exc_a, exc_b     captured codes per operand
//   exc_res          combined code (NaN over inf over normal)
//   timeout_err      set with done when an ACK never arrived
//   Data, Data_valid request to the checker
//   Exc, ACK         response from the checker (Exc valid only with ACK)
//   res_data         special result, only with EXC_SPECIAL_RESULT_EN defined
//
// Optional feature macro: EXC_SPECIAL_RESULT_EN
// All outputs are registered; they are decoded from the next state.
// ---------------------------------------------------------------------------
module exc_check_requester
  import exc_pkg::*;
#(
  parameter int ACK_TIMEOUT = 8,
  parameter int TMO_W       = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [2:0]  exc_a,
  output logic [2:0]  exc_b,
  output logic [2:0]  exc_res,
  output logic        timeout_err,
  output logic [31:0] Data,
  output logic        Data_valid,
  input  logic [2:0]  Exc,
  input  logic        ACK
`ifdef EXC_SPECIAL_RESULT_EN
  ,
  output logic [31:0] res_data
`endif
);

  // The counter holds the number of WAIT cycles already spent without ACK;
  // the last allowed cycle is therefore ACK_TIMEOUT-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  req_state_e        state_reg, state_next;
  logic [31:0]       op_a_reg, op_a_next;
  logic [31:0]       op_b_reg, op_b_next;
  logic [TMO_W-1:0]  cnt_reg, cnt_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [31:0]       data_reg, data_next;
  logic              data_valid_reg, data_valid_next;
  logic [2:0]        exc_a_reg, exc_a_next;
  logic [2:0]        exc_b_reg, exc_b_next;
  logic [2:0]        exc_res_reg, exc_res_next;
  logic              timeout_err_reg, timeout_err_next;
`ifdef EXC_SPECIAL_RESULT_EN
  logic [31:0]       res_data_reg, res_data_next;
`endif

  always_comb begin
    state_next       = state_reg;
    op_a_next        = op_a_reg;
    op_b_next        = op_b_reg;
    cnt_next         = '0;
    exc_a_next       = exc_a_reg;
    exc_b_next       = exc_b_reg;
    exc_res_next     = exc_res_reg;
    timeout_err_next = timeout_err_reg;
`ifdef EXC_SPECIAL_RESULT_EN
    res_data_next    = res_data_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          op_a_next        = op_a;
          op_b_next        = op_b;
          exc_a_next       = EXC_NORMAL;
          exc_b_next       = EXC_NORMAL;
          exc_res_next     = EXC_NORMAL;
          timeout_err_next = 1'b0;
`ifdef EXC_SPECIAL_RESULT_EN
          res_data_next    = '0;
`endif
          state_next       = ST_REQ_A;
        end
      end
      // ACK is deliberately not looked at in the REQ states: a pulse seen
      // here belongs to an earlier request.
      ST_REQ_A: state_next = ST_WAIT_A;
      ST_WAIT_A: begin
        if (ACK) begin
          exc_a_next = exc_normalize(Exc);
          state_next = ST_REQ_B;
        end else if (cnt_reg == TMO_LAST) begin
          exc_a_next       = EXC_NAN;
          timeout_err_next = 1'b1;
          state_next       = ST_DONE;
        end else begin
          cnt_next = cnt_reg + TMO_W'(1);
        end
      end
      ST_REQ_B: state_next = ST_WAIT_B;
      ST_WAIT_B: begin
        if (ACK) begin
          exc_b_next = exc_normalize(Exc);
          state_next = ST_DONE;
        end else if (cnt_reg == TMO_LAST) begin
          exc_b_next       = EXC_NAN;
          timeout_err_next = 1'b1;
          state_next       = ST_DONE;
        end else begin
          cnt_next = cnt_reg + TMO_W'(1);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // Results are formed on the edge that enters DONE, so they appear
    // together with done and then simply hold.
    if (state_next == ST_DONE) begin
      exc_res_next = exc_combine(exc_a_next, exc_b_next);
`ifdef EXC_SPECIAL_RESULT_EN
      if (exc_res_next == EXC_NAN)
        res_data_next = QNAN_CANON;
      else if (exc_res_next == EXC_INF)
        res_data_next = (exc_a_next == EXC_INF) ? op_a_reg : op_b_reg;
      else
        res_data_next = '0;
`endif
    end

    busy_next = (state_next != ST_IDLE);
    done_next = (state_next == ST_DONE);
    case (state_next)
      ST_REQ_A, ST_WAIT_A: begin
        data_valid_next = 1'b1;
        data_next       = op_a_next;
      end
      ST_REQ_B, ST_WAIT_B: begin
        data_valid_next = 1'b1;
        data_next       = op_b_next;
      end
      default: begin
        data_valid_next = 1'b0;
        data_next       = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_reg       <= ST_IDLE;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      cnt_reg         <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      data_reg        <= '0;
      data_valid_reg  <= 1'b0;
      exc_a_reg       <= '0;
      exc_b_reg       <= '0;
      exc_res_reg     <= '0;
      timeout_err_reg <= 1'b0;
`ifdef EXC_SPECIAL_RESULT_EN
      res_data_reg    <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      op_a_reg        <= op_a_next;
      op_b_reg        <= op_b_next;
      cnt_reg         <= cnt_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      data_reg        <= data_next;
      data_valid_reg  <= data_valid_next;
      exc_a_reg       <= exc_a_next;
      exc_b_reg       <= exc_b_next;
      exc_res_reg     <= exc_res_next;
      timeout_err_reg <= timeout_err_next;
`ifdef EXC_SPECIAL_RESULT_EN
      res_data_reg    <= res_data_next;
`endif
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign Data        = data_reg;
  assign Data_valid  = data_valid_reg;
  assign exc_a       = exc_a_reg;
  assign exc_b       = exc_b_reg;
  assign exc_res     = exc_res_reg;
  assign timeout_err = timeout_err_reg;
`ifdef EXC_SPECIAL_RESULT_EN
  assign res_data    = res_data_reg;
`endif

endmodule

// File: tb/tb_exc_check_requester.sv
// ---------------------------------------------------------------------------
// tb_exc_check_requester
// Drives exc_check_requester with directed and $urandom transactions. The
// bench plays the checker (samples on alternate cycles, registered ACK) and
// predicts codes, latency and special result from the operand-level rules.
// Optional feature macro: EXC_SPECIAL_RESULT_EN
// ---------------------------------------------------------------------------
module tb_exc_check_requester;

  localparam int ACK_TIMEOUT = 8;

  logic        CLK;
  logic        RSTN;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [2:0]  exc_a, exc_b, exc_res;
  logic        timeout_err;
  logic [31:0] Data;
  logic        Data_valid;
  logic [2:0]  Exc;
  logic        ACK;
`ifdef EXC_SPECIAL_RESULT_EN
  logic [31:0] res_data;
`endif

  exc_check_requester #(.ACK_TIMEOUT(ACK_TIMEOUT), .TMO_W(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .exc_a(exc_a), .exc_b(exc_b), .exc_res(exc_res),
    .timeout_err(timeout_err), .Data(Data), .Data_valid(Data_valid),
    .Exc(Exc), .ACK(ACK)
`ifdef EXC_SPECIAL_RESULT_EN
    , .res_data(res_data)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // checker model state
  int          cyc = 0;
  logic        own_ack = 1'b0, pending = 1'b0, stale_req = 1'b0, ack_en = 1'b0;
  logic [2:0]  ack_code = 3'b0, pend_code = 3'b0, raw_a = 3'b0, raw_b = 3'b0;
  int          acks_given = 0, ack_lim = 2;
  logic [31:0] seen_q[$];
  logic        done_seen = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // operand-level classification and combining rules
  function automatic logic [2:0] classify(input logic [31:0] v);
    if (v[30:23] != 8'hFF) return 3'b000;
    return (v[22:0] == 23'd0) ? 3'b011 : 3'b100;
  endfunction

  function automatic logic [2:0] norm(input logic [2:0] c);
    return (c == 3'b000 || c == 3'b011) ? c : 3'b100;
  endfunction

  // One clock: advance to the negedge, update the checker model and drive
  // ACK/Exc for the coming rising edge. Outputs are then stable to sample.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (!RSTN) begin
      own_ack = 1'b0;
      pending = 1'b0;
    end else begin
      own_ack  = pending;
      ack_code = pend_code;
      if (own_ack) acks_given++;
      pending = ack_en && (acks_given < ack_lim) && Data_valid && !own_ack && (cyc % 2 == 0);
      if (pending) begin
        seen_q.push_back(Data);
        pend_code = (acks_given == 0) ? raw_a : raw_b;
      end
    end
    ACK = own_ack | stale_req;
    Exc = own_ack ? ack_code : (stale_req ? 3'b100 : 3'($urandom));
    stale_req = 1'b0;
    if (done) done_seen = 1'b1;
  endtask

  task automatic run_txn(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ra, input logic [2:0] rb, input int lim,
                         input bit aligned, input bit stale);
    int n;
    logic [2:0]  ea, eb, er;
    logic        eto;
    int          elat;
    logic [31:0] eres;
    // cycle 1 of the transaction samples on the checker's phase iff aligned
    if ((((cyc + 1) % 2) == 0) != aligned) tick();
    raw_a = ra; raw_b = rb; ack_lim = lim; ack_en = 1'b1; acks_given = 0;
    seen_q.delete();
    op_a = a; op_b = b; start = 1'b1;
    stale_req = stale;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    if (lim == 0) begin
      ea = 3'b100; eb = 3'b000; eto = 1'b1; elat = ACK_TIMEOUT + 2;
    end else if (lim == 1) begin
      ea = norm(ra); eb = 3'b100; eto = 1'b1; elat = (aligned ? 2 : 3) + 2 + ACK_TIMEOUT;
    end else begin
      ea = norm(ra); eb = norm(rb); eto = 1'b0; elat = aligned ? 5 : 6;
    end
    er = (ea == 3'b100 || eb == 3'b100) ? 3'b100 :
         ((ea == 3'b011 || eb == 3'b011) ? 3'b011 : 3'b000);
    eres = (er == 3'b100) ? 32'h7FC00000 : ((er == 3'b011) ? ((ea == 3'b011) ? a : b) : 32'h0);
    check_val({nm, "_latency"}, 32'(n), 32'(elat));
    check_val({nm, "_exc_a"}, 32'(exc_a), 32'(ea));
    check_val({nm, "_exc_b"}, 32'(exc_b), 32'(eb));
    check_val({nm, "_exc_res"}, 32'(exc_res), 32'(er));
    check_val({nm, "_timeout"}, 32'(timeout_err), 32'(eto));
    check_val({nm, "_dv_in_done"}, 32'(Data_valid), 32'd0);
    check_val({nm, "_busy_in_done"}, 32'(busy), 32'd1);
`ifdef EXC_SPECIAL_RESULT_EN
    check_val({nm, "_res_data"}, res_data, eres);
`endif
    check_val({nm, "_req_count"}, 32'(seen_q.size()), 32'((lim > 2) ? 2 : lim));
    if (lim >= 1 && seen_q.size() >= 1) check_val({nm, "_data_a"}, seen_q[0], a);
    if (lim >= 2 && seen_q.size() >= 2) check_val({nm, "_data_b"}, seen_q[1], b);
    $display("TXN %s a=%h b=%h aligned=%0d lat=%0d exc_a=%b exc_b=%b exc_res=%b tmo=%0d eres=%h",
             nm, a, b, aligned, n, exc_a, exc_b, exc_res, timeout_err, eres);
    tick();
    check_val({nm, "_done_pulse"}, 32'(done), 32'd0);
    check_val({nm, "_idle_busy"}, 32'(busy), 32'd0);
    check_val({nm, "_held_res"}, 32'(exc_res), 32'(er));
  endtask

  task automatic check_all_zero(input string nm);
    check_val({nm, "_busy"}, 32'(busy), 32'd0);
    check_val({nm, "_done"}, 32'(done), 32'd0);
    check_val({nm, "_data"}, Data, 32'd0);
    check_val({nm, "_dv"}, 32'(Data_valid), 32'd0);
    check_val({nm, "_exc_a"}, 32'(exc_a), 32'd0);
    check_val({nm, "_exc_b"}, 32'(exc_b), 32'd0);
    check_val({nm, "_exc_res"}, 32'(exc_res), 32'd0);
    check_val({nm, "_timeout"}, 32'(timeout_err), 32'd0);
`ifdef EXC_SPECIAL_RESULT_EN
    check_val({nm, "_res_data"}, res_data, 32'd0);
`endif
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      0: v = v;
      1: v = {v[31], 8'hFF, 23'd0};
      2: v = {v[31], 8'hFF, v[22:1], 1'b1};
      default: v = v[0] ? 32'h3F800000 : 32'h00000000;
    endcase
    return v;
  endfunction

  initial begin
    RSTN = 1'b0; start = 1'b0; op_a = '0; op_b = '0; ACK = 1'b0; Exc = 3'b0;
    repeat (3) tick();
    check_all_zero("reset");
    RSTN = 1'b1;
    tick();

    run_txn("normal_al", 32'h3F800000, 32'h40000000, 3'b000, 3'b000, 2, 1'b1, 1'b0);
    run_txn("inf_nan", 32'h7F800000, 32'h7FC00001, 3'b011, 3'b100, 2, 1'b1, 1'b0);
    run_txn("neginf_zero", 32'hFF800000, 32'h00000000, 3'b011, 3'b000, 2, 1'b0, 1'b0);
    run_txn("zero_posinf", 32'h00000000, 32'h7F800000, 3'b000, 3'b011, 2, 1'b1, 1'b0);
    run_txn("stale_al", 32'h3F800000, 32'h40000000, 3'b000, 3'b000, 2, 1'b1, 1'b1);
    run_txn("stale_mis", 32'h3F800000, 32'h40000000, 3'b000, 3'b000, 2, 1'b0, 1'b1);
    run_txn("bad_code", 32'h3F800000, 32'h40000000, 3'b101, 3'b011, 2, 1'b1, 1'b0);
    run_txn("tmo_a", 32'h3F800000, 32'h40000000, 3'b000, 3'b000, 0, 1'b1, 1'b0);
    run_txn("tmo_b", 32'h7F800000, 32'h40000000, 3'b011, 3'b000, 1, 1'b0, 1'b0);

    // reset while waiting on B, with ignored start pulses beforehand
    if (((cyc + 1) % 2) != 0) tick();
    raw_a = 3'b000; raw_b = 3'b000; ack_lim = 1; ack_en = 1'b1; acks_given = 0;
    seen_q.delete(); done_seen = 1'b0;
    op_a = 32'h3F800000; op_b = 32'h40400000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check_val("rst_wb_data", Data, 32'h40400000);
    check_val("rst_wb_dv", 32'(Data_valid), 32'd1);
    op_a = 32'h11111111; op_b = 32'h22222222; start = 1'b1;
    repeat (2) tick();
    check_val("busy_start_data", Data, 32'h40400000);
    check_val("busy_start_busy", 32'(busy), 32'd1);
    start = 1'b0;
    RSTN = 1'b0;
    tick();
    check_all_zero("midrst");
    RSTN = 1'b1;
    tick();
    check_val("midrst_idle", 32'(busy), 32'd0);
    check_val("midrst_no_done", 32'(done_seen), 32'd0);
    $display("TXN midrst a=3f800000 b=40400000 reset_in_wait_b");
    run_txn("after_rst", 32'h7FC00000, 32'h7F800000, 3'b100, 3'b011, 2, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic [2:0]  ra, rb;
      int          lim;
      a = rand_op(); b = rand_op();
      ra = ($urandom_range(0, 7) == 0) ? 3'($urandom) : classify(a);
      rb = ($urandom_range(0, 7) == 0) ? 3'($urandom) : classify(b);
      case ($urandom_range(0, 9))
        0: lim = 0;
        1: lim = 1;
        default: lim = 2;
      endcase
      run_txn($sformatf("rnd%0d", i), a, b, ra, rb, lim, 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
